// File: rtl/hack_loader_pkg.sv
// Shared types and constants for the Hack ROM image loader.
// Loader states and stream framing widths.
package hack_loader_pkg;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CSUM,
    DONE,
    ERROR
  } state_t;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 2;
  localparam int LEN_W      = LEN_BYTES * 8;
  localparam int WORD_W     = WORD_BYTES * 8;

endpackage

// File: rtl/hack_rom_loader.sv
// Length-prefixed byte-stream loader for the Hack instruction ROM.
// Optional trailing checksum byte: define HACK_LOADER_CHECKSUM_EN.
module hack_rom_loader
  import hack_loader_pkg::*;
#(
  parameter int ROM_DEPTH = 1024,
  parameter int ADDR_W    = $clog2(ROM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [WORD_W-1:0] rom_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  words_loaded
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(ROM_DEPTH - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(ROM_DEPTH);

`ifdef HACK_LOADER_CHECKSUM_EN
  localparam state_t END_ST = CSUM;
`else
  localparam state_t END_ST = DONE;
`endif
  localparam logic END_DONE = (END_ST == DONE);

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [7:0]       hi;
  logic             accept;
  logic [LEN_W-1:0] len_next;
  logic             last_word;
`ifdef HACK_LOADER_CHECKSUM_EN
  logic [7:0]       sum;
`endif

  always_comb begin
    in_ready = 1'b0;
    unique case (1'b1)
      state == LEN_HI:  in_ready = 1'b1;
      state == LEN_LO:  in_ready = 1'b1;
      state == DATA_HI: in_ready = 1'b1;
      state == DATA_LO: in_ready = 1'b1;
`ifdef HACK_LOADER_CHECKSUM_EN
      state == CSUM:    in_ready = 1'b1;
`endif
      default:          in_ready = 1'b0;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign len_next  = {len[LEN_W-1:8], in_data};
  assign last_word = (words_loaded == len - LEN_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= LEN_HI;
      len          <= '0;
      hi           <= '0;
      rom_we       <= 1'b0;
      rom_addr     <= '0;
      rom_wdata    <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
`ifdef HACK_LOADER_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      rom_we <= 1'b0;
      // Address moves on after the write, saturating at the top word.
      if (rom_we && rom_addr != ADDR_MAX)
        rom_addr <= rom_addr + ADDR_W'(1);
      case (state)
        LEN_HI: if (accept) begin
          len[LEN_W-1:8] <= in_data;
          state          <= LEN_LO;
        end
        LEN_LO: if (accept) begin
          len <= len_next;
          if (len_next > LEN_MAX) begin
            state <= ERROR;
            error <= 1'b1;
          end else if (len_next == '0) begin
            state    <= END_ST;
            done     <= END_DONE;
            cpu_hold <= !END_DONE;
          end else begin
            state <= DATA_HI;
          end
        end
        DATA_HI: if (accept) begin
          hi    <= in_data;
          state <= DATA_LO;
`ifdef HACK_LOADER_CHECKSUM_EN
          sum   <= sum + in_data;
`endif
        end
        DATA_LO: if (accept) begin
          rom_we       <= 1'b1;
          rom_wdata    <= {hi, in_data};
          rom_addr     <= words_loaded[ADDR_W-1:0];
          words_loaded <= words_loaded + LEN_W'(1);
`ifdef HACK_LOADER_CHECKSUM_EN
          sum          <= sum + in_data;
`endif
          if (last_word) begin
            state    <= END_ST;
            done     <= END_DONE;
            cpu_hold <= !END_DONE;
          end else begin
            state <= DATA_HI;
          end
        end
`ifdef HACK_LOADER_CHECKSUM_EN
        CSUM: if (accept) begin
          if (in_data == sum) begin
            state    <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state <= ERROR;
            error <= 1'b1;
          end
        end
`endif
        DONE, ERROR: if (start) begin
          state        <= LEN_HI;
          done         <= 1'b0;
          error        <= 1'b0;
          words_loaded <= '0;
          rom_addr     <= '0;
          cpu_hold     <= 1'b1;
`ifdef HACK_LOADER_CHECKSUM_EN
          sum          <= '0;
`endif
        end
        default: state <= LEN_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed and randomized checks of hack_rom_loader against an image model.
module tb_hack_rom_loader;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          rom_we;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [15:0]   words_loaded;

  hack_rom_loader #(.ROM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  logic [25:0] wq[$];
  logic [15:0] img[$];

  always @(negedge clk)
    if (rom_we) wq.push_back({rom_addr, rom_wdata});

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit rnd);
    int n;
    @(negedge clk);
    n = 0;
    if (rnd)
      while ($urandom_range(1, 0) == 1 && n < 20) begin
        in_valid = 1'b0;
        @(negedge clk);
        n++;
      end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      stalls++;
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Stream header, words and optional checksum; compare against image.
  task automatic run_image(input int n, input bit rnd, input bit bad);
    logic [7:0] sum;
    int exp_w;
    bit exp_err;
    wq.delete();
    stalls = 0;
    sum = 8'h00;
    send(n[15:8], rnd);
    send(n[7:0], rnd);
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        send(img[i][15:8], rnd);
        send(img[i][7:0], rnd);
        sum = sum + img[i][15:8] + img[i][7:0];
      end
`ifdef HACK_LOADER_CHECKSUM_EN
      send(bad ? sum + 8'd1 : sum, rnd);
`endif
    end
    idle();
    exp_w   = (n > DEPTH) ? 0 : n;
    exp_err = (n > DEPTH) || bad;
    chk("nwrites", wq.size(), exp_w);
    for (int i = 0; i < exp_w && i < wq.size(); i++)
      chk("write", {6'b0, wq[i]}, {6'b0, AW'(i), img[i]});
    chk("done", {31'b0, done}, {31'b0, !exp_err});
    chk("error", {31'b0, error}, {31'b0, exp_err});
    chk("cpu_hold", {31'b0, cpu_hold}, {31'b0, exp_err});
    chk("words_loaded", {16'b0, words_loaded}, exp_w);
    chk("ready_end", {31'b0, in_ready}, 32'd0);
    chk("we_idle", {31'b0, rom_we}, 32'd0);
  endtask

  task automatic restart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rs_done", {31'b0, done}, 32'd0);
    chk("rs_error", {31'b0, error}, 32'd0);
    chk("rs_hold", {31'b0, cpu_hold}, 32'd1);
    chk("rs_words", {16'b0, words_loaded}, 32'd0);
    chk("rs_addr", {22'b0, rom_addr}, 32'd0);
    chk("rs_ready", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_hold", {31'b0, cpu_hold}, 32'd1);
    chk("rst_we", {31'b0, rom_we}, 32'd0);
    chk("rst_addr", {22'b0, rom_addr}, 32'd0);
    chk("rst_wdata", {16'b0, rom_wdata}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    chk("rst_words", {16'b0, words_loaded}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);

    img = '{16'hEC10, 16'hE308, 16'h0010};
    run_image(3, 1'b0, 1'b0);
    chk("no_bubbles", stalls, 32'd0);
    restart();

    img.delete();
    run_image(0, 1'b0, 1'b0);
    restart();

    run_image(32'h0401, 1'b0, 1'b0);
    restart();

    img = '{16'hEC10, 16'hE308, 16'h0010};
    run_image(3, 1'b1, 1'b0);
    restart();

    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(12, 1);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(16'($urandom));
      run_image(n, 1'b1, 1'b0);
      restart();
    end

    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back(16'($urandom));
    run_image(DEPTH, 1'b0, 1'b0);
    chk("addr_nowrap", {22'b0, rom_addr}, DEPTH - 1);
    restart();

    wq.delete();
    send(8'h00, 1'b0);
    send(8'h04, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("ar_hold", {31'b0, cpu_hold}, 32'd1);
    chk("ar_we", {31'b0, rom_we}, 32'd0);
    chk("ar_words", {16'b0, words_loaded}, 32'd0);
    chk("ar_addr", {22'b0, rom_addr}, 32'd0);
    chk("ar_done", {31'b0, done}, 32'd0);
    chk("ar_partial", wq.size(), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    img = '{16'hABCD};
    run_image(1, 1'b0, 1'b0);

`ifdef HACK_LOADER_CHECKSUM_EN
    restart();
    img = '{16'h1234};
    run_image(1, 1'b0, 1'b0);
    restart();
    run_image(1, 1'b0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
